// File: rtl/input_cond_pkg.sv
// Shared constants and helpers for the board input conditioning path.
// Latency: n/a (package). Backpressure: n/a.
// Holds bit counts and the debounce counter width calculation.
package input_cond_pkg;

    localparam int N_KEY            = 4;
    localparam int N_SW             = 8;
    localparam int DEFAULT_DEBOUNCE = 500000;

    // Smallest width able to hold DEBOUNCE_CYCLES-1, never less than one bit.
    function automatic int cnt_width(input int cycles);
        int w;
        w = 1;
        for (int k = 1; k < 31; k++) begin
            if ((1 << w) < cycles) begin
                w = w + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/debounce_bit.sv
// Purpose: two-flop synchronizer plus stable-count debouncer for one raw pin.
// Latency: DEBOUNCE_CYCLES+2 edges from a stable raw change to clean.
// Backpressure: none; free-running, accepts a new sample every cycle.
module debounce_bit
    import input_cond_pkg::*;
#(
    parameter int   DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE,
    parameter logic RESET_VAL       = 1'b0
) (
    input  logic core_clk,
    input  logic rst,
    input  logic raw,
    output logic clean,
    output logic fall
);

    localparam int            CW       = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync_1;
    logic          sync_2;
    logic [CW-1:0] cnt;

    always_ff @(posedge core_clk) begin
        if (rst) begin
            sync_1 <= RESET_VAL;
            sync_2 <= RESET_VAL;
            clean  <= RESET_VAL;
            cnt    <= '0;
            fall   <= 1'b0;
        end else begin
            sync_1 <= raw;
            sync_2 <= sync_1;
            fall   <= 1'b0;
            if (sync_2 == clean) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                // Accept: fall pulses in the same cycle clean first reads 0.
                clean <= sync_2;
                cnt   <= '0;
                fall  <= clean;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/input_conditioner.sv
// Purpose: debounce board keys/switches for the SoC PIOs; key press pulses and sticky flags.
// Latency: DEBOUNCE_CYCLES+2 edges raw->clean; key_press with clean, key_event one edge later.
// Backpressure: none; event_clr clears sticky flags, a coincident press wins.
module input_conditioner
    import input_cond_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE
) (
    input  logic             CLOCK_50,
    input  logic             Reset,
    input  logic [N_KEY-1:0] KEY_raw,
    input  logic [N_SW-1:0]  SW_raw,
    input  logic [N_KEY-1:0] event_clr,
    output logic [N_KEY-1:0] key_clean,
    output logic [N_SW-1:0]  sw_clean,
    output logic [N_KEY-1:0] key_press,
    output logic [N_KEY-1:0] key_event
);

    logic [N_SW-1:0] sw_fall_unused;

    // Keys idle high (active-low buttons), so they reset released.
    for (genvar i = 0; i < N_KEY; i++) begin : g_key
        debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .RESET_VAL       (1'b1)
        ) u_db (
            .core_clk (CLOCK_50),
            .rst      (Reset),
            .raw      (KEY_raw[i]),
            .clean    (key_clean[i]),
            .fall     (key_press[i])
        );
    end

    for (genvar i = 0; i < N_SW; i++) begin : g_sw
        debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .RESET_VAL       (1'b0)
        ) u_db (
            .core_clk (CLOCK_50),
            .rst      (Reset),
            .raw      (SW_raw[i]),
            .clean    (sw_clean[i]),
            .fall     (sw_fall_unused[i])
        );
    end

    always_ff @(posedge CLOCK_50) begin
        if (Reset) begin
            key_event <= '0;
        end else begin
            key_event <= (key_event & ~event_clr) | key_press;
        end
    end

endmodule
